// File: rtl/rv_wb_arbiter.sv
// Two-master (fetch, load/store) to one-slave classic Wishbone arbiter.
// Registered grant, data-first priority with fetch anti-starvation, per-transfer timeout.
module rv_wb_arbiter #(
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned DATA_BURST_MAX = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ins_cyc,
  input  logic [31:0] i_ins_adr,
  output logic [31:0] o_ins_dat,
  output logic        o_ins_ack,
  output logic        o_ins_err,
  input  logic        i_dat_cyc,
  input  logic [31:0] i_dat_adr,
  input  logic [31:0] i_dat_dat,
  input  logic        i_dat_we,
  input  logic [3:0]  i_dat_sel,
  output logic [31:0] o_dat_dat,
  output logic        o_dat_ack,
  output logic        o_dat_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack
);

  localparam int unsigned WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BURST_W = (DATA_BURST_MAX > 0) ? $clog2(DATA_BURST_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DATA_BURST_MAX);
  localparam logic               TO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_INS, S_DAT} state_t;

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;

  logic ins_busy, dat_busy, gnt_cyc, timeout_hit, fwd_ack, fwd_err;
  logic burst_full;

  assign ins_busy    = (state == S_INS);
  assign dat_busy    = (state == S_DAT);
  assign gnt_cyc     = (ins_busy & i_ins_cyc) | (dat_busy & i_dat_cyc);
  assign timeout_hit = TO_EN & (wait_cnt == WAIT_LAST) & ~i_wb_ack;
  assign burst_full  = (burst_cnt == BURST_MAX);

  // Responses reach only the granted, still-requesting port; reset masks a pending ack.
  assign fwd_ack   = i_reset_n & gnt_cyc & i_wb_ack;
  assign fwd_err   = i_reset_n & gnt_cyc & timeout_hit;
  assign o_ins_ack = ins_busy & fwd_ack;
  assign o_ins_err = ins_busy & fwd_err;
  assign o_dat_ack = dat_busy & fwd_ack;
  assign o_dat_err = dat_busy & fwd_err;
  assign o_ins_dat = ins_busy ? i_wb_dat : 32'd0;
  assign o_dat_dat = dat_busy ? i_wb_dat : 32'd0;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      o_wb_adr  <= 32'd0;
      o_wb_dat  <= 32'd0;
      o_wb_we   <= 1'b0;
      o_wb_sel  <= 4'd0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (!i_ins_cyc) burst_cnt <= '0;
          if (i_dat_cyc && !(i_ins_cyc && burst_full)) begin
            state    <= S_DAT;
            o_wb_adr <= i_dat_adr;
            o_wb_dat <= i_dat_dat;
            o_wb_we  <= i_dat_we;
            o_wb_sel <= i_dat_sel;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            if (i_ins_cyc && !burst_full) burst_cnt <= burst_cnt + BURST_W'(1);
          end else if (i_ins_cyc) begin
            state     <= S_INS;
            o_wb_adr  <= i_ins_adr;
            o_wb_dat  <= 32'd0;
            o_wb_we   <= 1'b0;
            o_wb_sel  <= 4'hF;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            burst_cnt <= '0;
          end
        end
        S_INS, S_DAT: begin
          // Ack, timeout or abort all end the transfer; address lines are held.
          if (!gnt_cyc || i_wb_ack || timeout_hit) begin
            state    <= S_IDLE;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
          o_wb_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed self-checking bench for rv_wb_arbiter (TIMEOUT=16, DATA_BURST_MAX=2).
module tb_rv_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_ins_cyc;
  logic [31:0] i_ins_adr;
  logic [31:0] o_ins_dat;
  logic        o_ins_ack, o_ins_err;
  logic        i_dat_cyc;
  logic [31:0] i_dat_adr, i_dat_dat;
  logic        i_dat_we;
  logic [3:0]  i_dat_sel;
  logic [31:0] o_dat_dat;
  logic        o_dat_ack, o_dat_err;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic        o_wb_cyc, o_wb_stb;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  rv_wb_arbiter #(.TIMEOUT(16), .DATA_BURST_MAX(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_ins_cyc(i_ins_cyc), .i_ins_adr(i_ins_adr), .o_ins_dat(o_ins_dat),
    .o_ins_ack(o_ins_ack), .o_ins_err(o_ins_err),
    .i_dat_cyc(i_dat_cyc), .i_dat_adr(i_dat_adr), .i_dat_dat(i_dat_dat),
    .i_dat_we(i_dat_we), .i_dat_sel(i_dat_sel), .o_dat_dat(o_dat_dat),
    .o_dat_ack(o_dat_ack), .o_dat_err(o_dat_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven mid-cycle, away from the edge.
  task automatic next();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, ".cyc"}, 32'(o_wb_cyc), 32'd0);
    check({tag, ".stb"}, 32'(o_wb_stb), 32'd0);
    check({tag, ".we"},  32'(o_wb_we),  32'd0);
  endtask

  logic [31:0] exp_adr [4];
  logic        exp_ins [4];

  initial begin
    i_reset_n = 1'b0;
    i_ins_cyc = 1'b0; i_ins_adr = 32'd0;
    i_dat_cyc = 1'b0; i_dat_adr = 32'd0; i_dat_dat = 32'd0; i_dat_we = 1'b0; i_dat_sel = 4'd0;
    i_wb_dat  = 32'd0; i_wb_ack = 1'b0;
    exp_adr = '{32'h1000, 32'h1000, 32'h300, 32'h1000};
    exp_ins = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values
    next(); next(); settle();
    check_idle_bus("rst");
    check("rst.adr", o_wb_adr, 32'd0);
    check("rst.sel", 32'(o_wb_sel), 32'd0);
    check("rst.acks", 32'({o_ins_ack, o_ins_err, o_dat_ack, o_dat_err}), 32'd0);
    check("rst.dat", o_ins_dat | o_dat_dat, 32'd0);
    i_reset_n = 1'b1;

    // Ack while idle is ignored
    next(); i_wb_ack = 1'b1; i_wb_dat = 32'h1234; settle();
    check("idle_ack.ins", 32'(o_ins_ack), 32'd0);
    check("idle_ack.dat", 32'(o_dat_ack), 32'd0);
    next(); i_wb_ack = 1'b0; settle();
    check("idle_ack.cyc", 32'(o_wb_cyc), 32'd0);

    // Single fetch, slave acks two cycles after cyc rises
    i_ins_cyc = 1'b1; i_ins_adr = 32'h100;
    next(); settle();
    check("f1.cyc", 32'(o_wb_cyc), 32'd1);
    check("f1.stb", 32'(o_wb_stb), 32'd1);
    check("f1.adr", o_wb_adr, 32'h100);
    check("f1.we", 32'(o_wb_we), 32'd0);
    check("f1.sel", 32'(o_wb_sel), 32'hF);
    check("f1.noack", 32'(o_ins_ack), 32'd0);
    next(); settle();
    check("f1.wait", 32'(o_ins_ack), 32'd0);
    next(); i_wb_ack = 1'b1; i_wb_dat = 32'h13; settle();
    check("f1.ack", 32'(o_ins_ack), 32'd1);
    check("f1.rdat", o_ins_dat, 32'h13);
    check("f1.dack", 32'(o_dat_ack), 32'd0);
    next(); i_wb_ack = 1'b0; i_ins_cyc = 1'b0; settle();
    check_idle_bus("f1.end");
    check("f1.ackgone", 32'(o_ins_ack), 32'd0);

    // Simultaneous requests: data first, then fetch
    next();
    i_ins_cyc = 1'b1; i_ins_adr = 32'h200;
    i_dat_cyc = 1'b1; i_dat_adr = 32'h8000_0004; i_dat_dat = 32'hDEADBEEF;
    i_dat_we = 1'b1; i_dat_sel = 4'b0011;
    next(); settle();
    check("sim.d.cyc", 32'(o_wb_cyc), 32'd1);
    check("sim.d.adr", o_wb_adr, 32'h8000_0004);
    check("sim.d.wdat", o_wb_dat, 32'hDEADBEEF);
    check("sim.d.we", 32'(o_wb_we), 32'd1);
    check("sim.d.sel", 32'(o_wb_sel), 32'h3);
    i_wb_ack = 1'b1; i_wb_dat = 32'h55; settle();
    check("sim.d.ack", 32'(o_dat_ack), 32'd1);
    check("sim.d.insack", 32'(o_ins_ack), 32'd0);
    check("sim.d.insdat", o_ins_dat, 32'd0);
    next(); i_wb_ack = 1'b0; i_dat_cyc = 1'b0; i_dat_we = 1'b0; settle();
    check_idle_bus("sim.gap");
    next(); settle();
    check("sim.i.cyc", 32'(o_wb_cyc), 32'd1);
    check("sim.i.adr", o_wb_adr, 32'h200);
    check("sim.i.we", 32'(o_wb_we), 32'd0);
    check("sim.i.sel", 32'(o_wb_sel), 32'hF);
    check("sim.i.wdat", o_wb_dat, 32'd0);
    i_wb_ack = 1'b1; i_wb_dat = 32'h77; settle();
    check("sim.i.ack", 32'(o_ins_ack), 32'd1);
    check("sim.i.rdat", o_ins_dat, 32'h77);
    check("sim.i.dack", 32'(o_dat_ack), 32'd0);
    next(); i_wb_ack = 1'b0; i_ins_cyc = 1'b0; settle();
    check("sim.end.cyc", 32'(o_wb_cyc), 32'd0);

    // Starvation guard: back-to-back loads with fetch held
    next();
    i_ins_cyc = 1'b1; i_ins_adr = 32'h300;
    i_dat_cyc = 1'b1; i_dat_adr = 32'h1000; i_dat_we = 1'b0; i_dat_sel = 4'hF;
    for (int g = 0; g < 4; g++) begin
      next(); settle();
      check($sformatf("starve%0d.adr", g), o_wb_adr, exp_adr[g]);
      i_wb_ack = 1'b1; settle();
      check($sformatf("starve%0d.iack", g), 32'(o_ins_ack), 32'(exp_ins[g]));
      check($sformatf("starve%0d.dack", g), 32'(o_dat_ack), 32'(!exp_ins[g]));
      next(); i_wb_ack = 1'b0; settle();
      check($sformatf("starve%0d.gap", g), 32'(o_wb_cyc), 32'd0);
    end
    i_ins_cyc = 1'b0; i_dat_cyc = 1'b0;

    // Timeout: no ack for 16 busy cycles
    next();
    i_dat_cyc = 1'b1; i_dat_adr = 32'h2000;
    next();
    for (int k = 1; k <= 16; k++) begin
      settle();
      check($sformatf("to.c%0d.cyc", k), 32'(o_wb_cyc), 32'd1);
      check($sformatf("to.c%0d.err", k), 32'(o_dat_err), 32'(k == 16));
      if (k < 16) next();
    end
    next(); i_dat_cyc = 1'b0; settle();
    check("to.end.cyc", 32'(o_wb_cyc), 32'd0);
    check("to.end.err", 32'(o_dat_err), 32'd0);

    // Ack arriving on the timeout cycle wins
    next();
    i_dat_cyc = 1'b1; i_dat_adr = 32'h2004;
    next();
    for (int k = 1; k < 16; k++) next();
    i_wb_ack = 1'b1; settle();
    check("to_ack.ack", 32'(o_dat_ack), 32'd1);
    check("to_ack.err", 32'(o_dat_err), 32'd0);
    next(); i_wb_ack = 1'b0; i_dat_cyc = 1'b0; settle();
    check("to_ack.cyc", 32'(o_wb_cyc), 32'd0);

    // Abort: fetch drops cyc in the same cycle the slave acks
    next();
    i_ins_cyc = 1'b1; i_ins_adr = 32'h400;
    next(); settle();
    check("ab.cyc", 32'(o_wb_cyc), 32'd1);
    next(); i_ins_cyc = 1'b0; i_wb_ack = 1'b1; settle();
    check("ab.ack", 32'(o_ins_ack), 32'd0);
    check("ab.err", 32'(o_ins_err), 32'd0);
    next(); i_wb_ack = 1'b0; settle();
    check("ab.end", 32'(o_wb_cyc), 32'd0);

    // Reset during a data transfer with a fetch pending
    next();
    i_ins_cyc = 1'b1; i_ins_adr = 32'h500;
    i_dat_cyc = 1'b1; i_dat_adr = 32'h3000; i_dat_dat = 32'hCAFE; i_dat_we = 1'b1; i_dat_sel = 4'hC;
    next(); settle();
    check("rm.we", 32'(o_wb_we), 32'd1);
    check("rm.adr", o_wb_adr, 32'h3000);
    i_reset_n = 1'b0; i_wb_ack = 1'b1; settle();
    check("rm.noack", 32'(o_dat_ack), 32'd0);
    next(); settle();
    check_idle_bus("rm.after");
    check("rm.adr0", o_wb_adr, 32'd0);
    check("rm.wdat0", o_wb_dat, 32'd0);
    check("rm.sel0", 32'(o_wb_sel), 32'd0);
    check("rm.dack0", 32'(o_dat_ack), 32'd0);
    i_reset_n = 1'b1; i_wb_ack = 1'b0; i_dat_cyc = 1'b0; i_dat_we = 1'b0;
    next(); settle();
    check("rm.ins.cyc", 32'(o_wb_cyc), 32'd1);
    check("rm.ins.adr", o_wb_adr, 32'h500);
    i_wb_ack = 1'b1; i_wb_dat = 32'h99; settle();
    check("rm.ins.ack", 32'(o_ins_ack), 32'd1);
    next(); i_wb_ack = 1'b0; i_ins_cyc = 1'b0; settle();
    check("rm.ins.end", 32'(o_wb_cyc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
